v30mz_prefetch_fifo: RTL

//  Byte-granular prefetch queue between the bus control unit and the opcode/modrm/disp/imm fetch FSM.
//  - Accepts 16-bit words from the data bus.
//  - Delivers instruction bytes to the fetch FSM one per pop.
//  - Tracks the prefetch pointer offset PFP; the BCU forms the fetch address as {PS,4'd0} + PFP.
//  - Handles odd-address flushes (branch, call, return, break, interrupt).

---
 rtl/v30mz_prefetch_fifo.sv | 98 +++++++++
 1 files changed

// File: rtl/v30mz_prefetch_fifo.sv
// Byte-granular instruction prefetch queue: 16-bit bus words in, one byte out per pop.
// Optional two-byte peek/pop port enabled by defining V30MZ_PFQ_PEEK2_EN.
module v30mz_prefetch_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [15:0]   flush_pfp,
  input  logic          push,
  input  logic [15:0]   data_in,
  input  logic          pop,
`ifdef V30MZ_PFQ_PEEK2_EN
  input  logic          pop2,
  output logic [7:0]    data_next,
`endif
  output logic [15:0]   PFP,
  output logic [7:0]    data_out,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         rp, wp, wp1, rp1;
  logic [CW-1:0]         free_bytes, count_next;
  logic [1:0]            n_push, n_pop;
  logic                  push_ok, odd;

  assign wp1        = wp + AW'(1);
  assign rp1        = rp + AW'(1);
  assign free_bytes = CW'(DEPTH) - count;
  assign empty      = (count == '0);
  assign full       = (free_bytes < CW'(2));
  assign odd        = PFP[0];
  assign push_ok    = push && !full;

  // Odd PFP means the even byte of this word precedes the branch target.
  always_comb begin
    n_push = 2'd0;
    if (push_ok) n_push = odd ? 2'd1 : 2'd2;
  end

`ifdef V30MZ_PFQ_PEEK2_EN
  // pop2 takes precedence over pop; when count < 2 the request is dropped.
  always_comb begin
    n_pop = 2'd0;
    if (pop2) begin
      if (count >= CW'(2)) n_pop = 2'd2;
    end else if (pop && !empty) begin
      n_pop = 2'd1;
    end
  end
  assign data_next = (count < CW'(2)) ? 8'h00 : mem[rp1];
`else
  always_comb begin
    n_pop = 2'd0;
    if (pop && !empty) n_pop = 2'd1;
  end
`endif

  assign count_next = count + CW'(n_push) - CW'(n_pop);
  assign data_out   = empty ? 8'h00 : mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      PFP   <= 16'h0000;
      count <= '0;
      rp    <= '0;
      wp    <= '0;
    end else if (flush) begin
      PFP   <= flush_pfp;
      count <= '0;
      rp    <= '0;
      wp    <= '0;
    end else begin
      PFP   <= PFP + 16'(n_push);
      count <= count_next;
      rp    <= rp + AW'(n_pop);
      wp    <= wp + AW'(n_push);
    end
  end

  // Array has no reset; data_out is gated by empty so stale bytes never leak.
  always_ff @(posedge clk) begin
    if (!reset && !flush && push_ok) begin
      if (odd) begin
        mem[wp] <= data_in[15:8];
      end else begin
        mem[wp]  <= data_in[7:0];
        mem[wp1] <= data_in[15:8];
      end
    end
  end

endmodule
